// File: rtl/alu_result_tx.sv
// Serial transmitter for the ALU result path: start, 8 data bits LSB first, carry-out,
// even parity over data+carry, stop. One frame per valid/ready handshake.
module alu_result_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] result_in,
    input  logic       cout_in,
    input  logic       send,
    output logic       ready,
    output logic       busy,
    output logic       tx,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_COUT   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity9(input logic [8:0] payload);
        return ^payload;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [8:0]      shreg_q, shreg_d;
    logic            parity_q, parity_d;
    logic            tx_q, tx_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            bit_end_s;

    // Next-state, shift datapath and the values the output flops take at the next edge
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        bit_end_s = (cnt_q == CNT_MAX);

        if ((state_q == ST_IDLE) || bit_end_s) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        // tx is computed for the state being entered so the flop leads nothing and lags nothing
        case (state_q)
            ST_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                idx_d   = 3'd0;
                if (send && ready_q) begin
                    shreg_d  = {cout_in, result_in};
                    parity_d = even_parity9({cout_in, result_in});
                    state_d  = ST_START;
                    tx_d     = 1'b0;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                    tx_d    = shreg_q[0];
                end else begin
                    tx_d    = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    // After the eighth shift the carry-out sits in bit 0
                    shreg_d = {1'b0, shreg_q[8:1]};
                    tx_d    = shreg_q[1];
                    if (idx_q == 3'd7) begin
                        state_d = ST_COUT;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    tx_d = shreg_q[0];
                end
            end
            ST_COUT: begin
                if (bit_end_s) begin
                    state_d = ST_PARITY;
                    tx_d    = parity_q;
                end else begin
                    tx_d    = shreg_q[0];
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end else begin
                    tx_d    = parity_q;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_end_s) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase

        busy_d = ~ready_d;
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            idx_q    <= 3'd0;
            shreg_q  <= 9'd0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Self-checking bench for alu_result_tx with CLKS_PER_BIT=4; expected frames come from
// a bit-list model built directly from the frame format.
module tb_alu_result_tx;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 12 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] result_in;
    logic       cout_in;
    logic       send;
    logic       ready;
    logic       busy;
    logic       tx;
    logic       done;

    int checks = 0;
    int errors = 0;

    alu_result_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .result_in (result_in),
        .cout_in   (cout_in),
        .send      (send),
        .ready     (ready),
        .busy      (busy),
        .tx        (tx),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference: frame bit i is the value on tx during the i-th bit period
    function automatic logic [11:0] model_frame(input logic [7:0] r, input logic c);
        logic [11:0] f;
        int ones;
        ones  = $countones({c, r});
        f[0]  = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = r[i];
        f[9]  = c;
        f[10] = ((ones % 2) == 1);
        f[11] = 1'b1;
        return f;
    endfunction

    // Records one frame starting the cycle after acceptance; status = {held, busy_ok, end_ok}
    task automatic observe_frame(output logic [11:0] bits, output logic [2:0] status);
        logic held_ok, busy_ok, end_ok;
        held_ok = 1'b1;
        busy_ok = 1'b1;
        bits    = 12'h000;
        for (int k = 0; k < FRAME_CYC; k++) begin
            @(negedge clk);
            if ((k % CPB) == 0) bits[k / CPB] = tx;
            else if (tx !== bits[k / CPB]) held_ok = 1'b0;
            if (busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) busy_ok = 1'b0;
        end
        @(negedge clk);
        end_ok = (done === 1'b1 && ready === 1'b1 && busy === 1'b0 && tx === 1'b1);
        status = {held_ok, busy_ok, end_ok};
    endtask

    task automatic start_frame(input logic [7:0] r, input logic c);
        @(negedge clk);
        result_in = r;
        cout_in   = c;
        send      = 1'b1;
        @(posedge clk);
        #1 send = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] b;
        logic [2:0]  st;
        logic [7:0]  r;
        logic        c;
        r = 8'($urandom_range(0, 255));
        c = 1'($urandom_range(0, 1));
        rst_n = 1'b0; send = 1'b1; result_in = r; cout_in = c;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, ready, busy, done} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_hold: {tx,ready,busy,done}=%b expected 1100", {tx, ready, busy, done});
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1 send = 1'b0;
        observe_frame(b, st);
        checks++;
        if (b !== model_frame(r, c)) begin
            errors++;
            $display("FAIL reset_first_frame: bits=%h expected %h", b, model_frame(r, c));
        end
        checks++;
        if (st !== 3'b111) begin
            errors++;
            $display("FAIL reset_first_status: status=%b expected 111", st);
        end
    endtask

    task automatic test_single_frame();
        logic [11:0] b;
        logic [2:0]  st;
        start_frame(8'hA5, 1'b1);
        observe_frame(b, st);
        checks++;
        if (b !== 12'hF4A) begin
            errors++;
            $display("FAIL single_bits: bits=%h expected f4a", b);
        end
        checks++;
        if (st !== 3'b111) begin
            errors++;
            $display("FAIL single_status: status=%b expected 111", st);
        end
        @(negedge clk);
        checks++;
        if ({done, ready, tx} !== 3'b011) begin
            errors++;
            $display("FAIL single_done_width: {done,ready,tx}=%b expected 011", {done, ready, tx});
        end
    endtask

    task automatic test_parity_corners();
        logic [11:0] b;
        logic [2:0]  st;
        logic [7:0]  vals [3];
        logic        par  [3];
        vals[0] = 8'h00; par[0] = 1'b0;
        vals[1] = 8'hFF; par[1] = 1'b0;
        vals[2] = 8'h01; par[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_frame(vals[i], 1'b0);
            observe_frame(b, st);
            checks++;
            if (b[10] !== par[i] || b[11] !== 1'b1) begin
                errors++;
                $display("FAIL parity_corner_%0d: parity=%b stop=%b expected parity=%b stop=1", i, b[10], b[11], par[i]);
            end
            checks++;
            if (b !== model_frame(vals[i], 1'b0) || st !== 3'b111) begin
                errors++;
                $display("FAIL parity_frame_%0d: bits=%h status=%b expected %h 111", i, b, st, model_frame(vals[i], 1'b0));
            end
        end
    endtask

    task automatic test_input_stability();
        logic [11:0] b;
        logic [2:0]  st;
        logic        c;
        c = 1'($urandom_range(0, 1));
        start_frame(8'h3C, c);
        fork
            observe_frame(b, st);
            begin
                result_in = 8'hC3;
                cout_in   = ~c;
                repeat (10) @(posedge clk);
                #1 send = 1'b1;
                @(posedge clk);
                #1 send = 1'b0;
            end
        join
        checks++;
        if (b !== model_frame(8'h3C, c) || st !== 3'b111) begin
            errors++;
            $display("FAIL stability_frame: bits=%h status=%b expected %h 111", b, st, model_frame(8'h3C, c));
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL stability_no_second: tx=%b busy=%b expected tx=1 busy=0", tx, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] b1, b2;
        logic [2:0]  s1, s2;
        start_frame(8'h12, 1'b0);
        send      = 1'b1;
        result_in = 8'h34;
        cout_in   = 1'b1;
        observe_frame(b1, s1);
        @(posedge clk);
        #1 send = 1'b0;
        observe_frame(b2, s2);
        checks++;
        if (b1 !== model_frame(8'h12, 1'b0) || s1 !== 3'b111) begin
            errors++;
            $display("FAIL b2b_first: bits=%h status=%b expected %h 111", b1, s1, model_frame(8'h12, 1'b0));
        end
        checks++;
        if (b2 !== model_frame(8'h34, 1'b1) || s2 !== 3'b111) begin
            errors++;
            $display("FAIL b2b_second: bits=%h status=%b expected %h 111", b2, s2, model_frame(8'h34, 1'b1));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, ready, done} !== 3'b110) begin
                errors++;
                $display("FAIL b2b_idle_after: {tx,ready,done}=%b expected 110", {tx, ready, done});
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] b;
        logic [2:0]  st;
        start_frame(8'h5A, 1'b1);
        repeat (17) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx, ready, busy, done} !== 4'b1100) begin
            errors++;
            $display("FAIL midreset_immediate: {tx,ready,busy,done}=%b expected 1100", {tx, ready, busy, done});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || tx !== 1'b1) begin
                errors++;
                $display("FAIL midreset_hold: done=%b tx=%b expected done=0 tx=1", done, tx);
            end
        end
        rst_n = 1'b1;
        start_frame(8'h81, 1'b0);
        observe_frame(b, st);
        checks++;
        if (b !== model_frame(8'h81, 1'b0) || st !== 3'b111) begin
            errors++;
            $display("FAIL midreset_recover: bits=%h status=%b expected %h 111", b, st, model_frame(8'h81, 1'b0));
        end
    endtask

    task automatic test_random();
        logic [11:0] b;
        logic [2:0]  st;
        logic [7:0]  r;
        logic        c;
        for (int n = 0; n < 8; n++) begin
            r = 8'($urandom_range(0, 255));
            c = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_frame(r, c);
            observe_frame(b, st);
            checks++;
            if (b !== model_frame(r, c) || st !== 3'b111) begin
                errors++;
                $display("FAIL random_%0d: r=%h c=%b bits=%h status=%b expected %h 111", n, r, c, b, st, model_frame(r, c));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity_corners();
        test_input_stability();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_result_tx.md
# alu_result_tx

Serial transmitter for the 8-bit ALU output path. It captures one ALU result byte plus carry-out on a valid/ready handshake and sends it on a single pin as a framed, parity-protected serial word. It sits between the ALU instance and one spare output pin of the top level, so results can be read off-chip with a plain UART-style receiver.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- result_in  input  8  ALU result to transmit.
- cout_in  input  1  ALU carry-out to transmit.
- send  input  1  request to transmit; sampled only while ready=1.
- ready  output  1  high when idle and able to accept a request.
- busy  output  1  high while a frame is in progress; always the inverse of ready.
- tx  output  1  serial line; idles high.
- done  output  1  one-cycle pulse when a frame completes.

## Operation
- Frame is 12 bits, sent in this order:
  - start bit (0)
  - result bits 0..7, LSB first
  - cout bit
  - even-parity bit over the 9 payload bits, so the total count of ones in data+cout+parity is even
  - stop bit (1)
- Acceptance happens at a rising edge where send=1 and ready=1.
  - result_in and cout_in are latched into a 9-bit shift register.
  - Parity is computed from the latched values.
  - The state moves from IDLE to START.
- States are IDLE, START, DATA, COUT, PARITY, STOP.
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shreg[0]; the register shifts right at each bit boundary, and a 3-bit index counts 0..7.
  - COUT: tx=latched cout.
  - PARITY: tx=parity.
  - STOP: tx=1.
- A bit counter runs 0..CLKS_PER_BIT-1. The state advances when the counter reaches CLKS_PER_BIT-1, and the counter wraps to 0 at that point.
- After STOP completes: return to IDLE, ready=1, and pulse done=1 for that first IDLE cycle only.
- While busy:
  - send is ignored.
  - Changes on result_in and cout_in have no effect on the frame in progress.
- tx is driven from a register, so it is glitch-free.

## Timing
- Reset values (asynchronous, immediate on rst_n low): tx=1, ready=1, busy=0, done=0, state IDLE, counters 0, shift register 0.
- Reset mid-frame aborts the frame immediately: tx returns to 1 and no done pulse is produced.
- Latency:
  - Acceptance at edge N: tx falls after edge N, i.e. the first cycle of START.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Frame occupies 12·CLKS_PER_BIT cycles from start-bit first cycle to stop-bit last cycle.
- done and ready rise together in the cycle after the last stop-bit cycle.
- Back-to-back: with send held high, the next frame is accepted at the first edge where ready=1. The START of that frame begins the following cycle, so the minimum frame period is 12·CLKS_PER_BIT+1 cycles and there is exactly one idle-high cycle between frames.
- A send pulse that is asserted and deasserted entirely while busy is lost. There is no queueing.
- done and a new acceptance can occur in the same cycle. The frame still starts normally.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: hold rst_n=0 with send=1 -> tx=1, ready=1, busy=0, done=0 throughout. Release -> acceptance at the first edge, tx=0 on the next cycle.
- Single frame: result_in=0xA5, cout_in=1, one-cycle send.
  - Required tx bit sequence, each bit held 4 cycles: 0, 1,0,1,0,0,1,0,1, 1, 1, 1 (48 cycles).
  - done pulses once at cycle 49 and ready returns to 1.
- Parity corners:
  - 0x00/cout 0 -> payload 0…0, parity 0.
  - 0xFF/cout 0 -> parity 0.
  - 0x01/cout 0 -> parity 1.
  - Check the stop bit is 1 in all three.
- Input stability: accept 0x3C, then change result_in to 0xC3 and pulse send during the frame -> transmitted data is 0x3C, and no second frame follows.
- Back-to-back: send held high with 0x12 then 0x34 -> two frames, frame period 49 cycles, exactly one idle-high cycle between them, done pulses at cycles 49 and 98.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx=1 and ready=1 immediately, no done pulse. After release, a new send of 0x81 transmits cleanly.
